// File: rtl/adder_rr_scheduler.sv
// Round-robin front end for one shared, registered WIDTH-bit adder.
// NUM_REQ requesters compete for a 2-stage stallable pipeline
// (operand stage -> sum stage). Each result returns tagged with the
// originating requester index.
module adder_rr_scheduler #(
  parameter int NUM_REQ = 4,
  parameter int WIDTH   = 32,
  parameter int ID_W    = 2
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [NUM_REQ-1:0]       req_valid,
  output logic [NUM_REQ-1:0]       req_ready,
  input  logic [NUM_REQ*WIDTH-1:0] req_a,
  input  logic [NUM_REQ*WIDTH-1:0] req_b,
  output logic                     resp_valid,
  input  logic                     resp_ready,
  output logic [WIDTH-1:0]         resp_sum,
  output logic                     resp_carry,
  output logic [ID_W-1:0]          resp_id,
  output logic [31:0]              op_count
);

  logic [ID_W-1:0]  rr_ptr;
  logic             grant_valid;
  logic [ID_W-1:0]  grant_id;
  int unsigned      idx;
  logic             accept;
  logic             s0_load;
  logic             s1_load;
  logic [WIDTH-1:0] sel_a;
  logic [WIDTH-1:0] sel_b;

  logic             s0_valid;
  logic [WIDTH-1:0] s0_a;
  logic [WIDTH-1:0] s0_b;
  logic [ID_W-1:0]  s0_id;
  logic             s1_valid;

  // Round-robin search starting at rr_ptr; first valid requester wins.
  always_comb begin
    grant_valid = 1'b0;
    grant_id    = '0;
    idx         = 0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      idx = (32'(rr_ptr) + k) % NUM_REQ;
      if (!grant_valid && req_valid[idx]) begin
        grant_valid = 1'b1;
        grant_id    = ID_W'(idx);
      end
    end
  end

  // Stall chain and the one-hot ready back to the winning requester.
  always_comb begin
    s1_load   = s0_valid & (~s1_valid | resp_ready);
    s0_load   = ~s0_valid | s1_load;
    accept    = grant_valid & s0_load & ~reset;
    req_ready = '0;
    if (accept) req_ready[grant_id] = 1'b1;
    sel_a     = req_a[32'(grant_id) * WIDTH +: WIDTH];
    sel_b     = req_b[32'(grant_id) * WIDTH +: WIDTH];
  end

  assign resp_valid = s1_valid;

  // Arbitration pointer: moves past the requester just accepted.
  always_ff @(posedge clock) begin
    if (reset) begin
      rr_ptr <= '0;
    end else if (accept) begin
      rr_ptr <= (grant_id == ID_W'(NUM_REQ - 1)) ? '0 : grant_id + 1'b1;
    end
  end

  // Stage 0: operand registers, refilled whenever the stage can move.
  always_ff @(posedge clock) begin
    if (reset) begin
      s0_valid <= 1'b0;
    end else if (s0_load) begin
      s0_valid <= accept;
      if (accept) begin
        s0_a  <= sel_a;
        s0_b  <= sel_b;
        s0_id <= grant_id;
      end
    end
  end

  // Stage 1: sum register; holds its result while downstream stalls.
  always_ff @(posedge clock) begin
    if (reset) begin
      s1_valid   <= 1'b0;
      resp_sum   <= '0;
      resp_carry <= 1'b0;
      resp_id    <= '0;
    end else if (s1_load) begin
      {resp_carry, resp_sum} <= {1'b0, s0_a} + {1'b0, s0_b};
      resp_id                <= s0_id;
      s1_valid               <= 1'b1;
    end else if (resp_ready) begin
      s1_valid <= 1'b0;
    end
  end

  // Completed-response counter, free-running wrap.
  always_ff @(posedge clock) begin
    if (reset) begin
      op_count <= '0;
    end else if (s1_valid && resp_ready) begin
      op_count <= op_count + 32'd1;
    end
  end

endmodule
